// File: rtl/i2c_pkg.sv
// Shared types for the I2C register-bank target: FSM states and R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    IGNORE,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C bus conditioner: 2-flop synchronisers on SCL/SDA, optional agreement
// glitch filter (macro I2C_GLITCH_FILTER_EN, length FILTER_LEN >= 2), then
// START/STOP and SCL rise/fall detection against a registered previous level.
module i2c_bus_cond #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_scl_sync, r_sda_sync;
  logic       w_scl, w_sda;
  logic       r_scl_prev, r_sda_prev;

  // Synchronise the asynchronous pad inputs; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [FILTER_LEN-1:0] r_scl_hist, r_sda_hist;
  logic                  r_scl_flt, r_sda_flt;

  // Filtered level only moves once every sample in the history agrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_flt  <= 1'b1;
      r_sda_flt  <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[FILTER_LEN-2:0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[FILTER_LEN-2:0], r_sda_sync[1]};
      if (&r_scl_hist)       r_scl_flt <= 1'b1;
      else if (~|r_scl_hist) r_scl_flt <= 1'b0;
      if (&r_sda_hist)       r_sda_flt <= 1'b1;
      else if (~|r_sda_hist) r_sda_flt <= 1'b0;
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  // Unfiltered build: the synchroniser feeds edge detection directly and
  // FILTER_LEN has no effect on the datapath.
  if (FILTER_LEN >= 0) begin : g_direct
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
  end
`endif

  // Previous-level copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign o_sda   = w_sda;
  assign o_rise  =  w_scl & ~r_scl_prev;
  assign o_fall  = ~w_scl &  r_scl_prev;
  assign o_start =  w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
  assign o_stop  =  w_scl & r_scl_prev & ~r_sda_prev &  w_sda;

endmodule

// File: rtl/i2c_slave_regbank.sv
// I2C target with a byte-wide register-bank port and auto-incrementing pointer.
// First write byte after the address sets the pointer; further bytes are
// written and the pointer advances. Reads stream from the pointer onwards.
// Optional glitch filter on SCL/SDA: define I2C_GLITCH_FILTER_EN.
module i2c_slave_regbank #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter int         DEPTH      = 16,
  parameter int         PTR_W      = $clog2(DEPTH),
  parameter int         FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2c_scl_in,
  input  logic             i2c_sda_in,
  output logic             i2c_sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr,
  input  logic [7:0]       reg_rdata,
  output logic             reg_rd,
  output logic             busy
);
  import i2c_pkg::*;

  logic w_sda, w_start, w_stop, w_rise, w_fall;

  i2c_bus_cond #(.FILTER_LEN(FILTER_LEN)) u_cond (
    .clk     (clk),
    .rst     (rst),
    .i_scl   (i2c_scl_in),
    .i_sda   (i2c_sda_in),
    .o_sda   (w_sda),
    .o_start (w_start),
    .o_stop  (w_stop),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  state_e           r_state, w_state;
  logic [2:0]       r_cnt, w_cnt;
  logic [7:0]       r_shift, w_shift;
  logic [7:0]       r_wdata, w_wdata;
  logic [PTR_W-1:0] r_ptr, w_ptr;
  logic             r_oe, w_oe;
  logic             r_ack_ph, w_ack_ph;   // ACK slot: 0 = before 9th clock, 1 = inside it
  logic             r_rw, w_rw;
  logic             r_busy, w_busy;
  logic             r_wr, w_wr;
  logic             w_rd;
  logic [7:0]       w_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  // Next-state and datapath decode; SDA drive only changes on an SCL fall.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_shift  = r_shift;
    w_wdata  = r_wdata;
    w_oe     = r_oe;
    w_ack_ph = r_ack_ph;
    w_rw     = r_rw;
    w_busy   = r_busy;
    w_wr     = 1'b0;
    w_rd     = 1'b0;
    // Pointer advances on the clk after a write strobe.
    w_ptr    = r_wr ? r_ptr + 1'b1 : r_ptr;

    if (w_start) begin
      w_state  = ADDR;
      w_cnt    = 3'd7;
      w_oe     = 1'b0;
      w_ack_ph = 1'b0;
    end else if (w_stop) begin
      w_state  = IDLE;
      w_oe     = 1'b0;
      w_busy   = 1'b0;
      w_ack_ph = 1'b0;
    end else begin
      case (r_state)
        ADDR, PTR, WR_DATA: begin
          if (w_rise) begin
            w_shift = w_byte;
            w_cnt   = r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
              w_ack_ph = 1'b0;
              if (r_state == ADDR) begin
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  w_state = ADDR_ACK;
                  w_rw    = w_byte[0];
                  w_busy  = 1'b1;
                end else begin
                  w_state = IGNORE;
                end
              end else if (r_state == PTR) begin
                w_ptr   = w_byte[PTR_W-1:0];
                w_state = PTR_ACK;
              end else begin
                w_wr    = 1'b1;
                w_wdata = w_byte;
                w_state = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (w_fall) begin
            if (!r_ack_ph) begin
              w_oe     = 1'b1;
              w_ack_ph = 1'b1;
            end else begin
              w_oe     = 1'b0;
              w_ack_ph = 1'b0;
              w_cnt    = 3'd7;
              if (r_state == ADDR_ACK && r_rw == RW_READ) begin
                w_rd    = 1'b1;
                w_shift = reg_rdata;
                w_oe    = ~reg_rdata[7];
                w_state = RD_DATA;
              end else if (r_state == ADDR_ACK) begin
                w_state = PTR;
              end else begin
                w_state = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (w_fall) begin
            w_shift = {r_shift[6:0], r_shift[7]};
            w_oe    = ~r_shift[6];
          end else if (w_rise) begin
            w_cnt = r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
              w_state  = RD_ACK;
              w_ack_ph = 1'b0;
            end
          end
        end
        RD_ACK: begin
          if (w_fall) begin
            if (r_ack_ph) begin
              w_rd     = 1'b1;
              w_shift  = reg_rdata;
              w_oe     = ~reg_rdata[7];
              w_cnt    = 3'd7;
              w_ack_ph = 1'b0;
              w_state  = RD_DATA;
            end else begin
              w_oe = 1'b0;
            end
          end else if (w_rise && !r_ack_ph) begin
            if (w_sda) begin
              w_state = IDLE;
              w_busy  = 1'b0;
              w_oe    = 1'b0;
            end else begin
              w_ptr    = r_ptr + 1'b1;
              w_ack_ph = 1'b1;
            end
          end
        end
        default: w_oe = 1'b0;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd7;
      r_shift  <= '0;
      r_wdata  <= '0;
      r_ptr    <= '0;
      r_oe     <= 1'b0;
      r_ack_ph <= 1'b0;
      r_rw     <= RW_WRITE;
      r_busy   <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_shift  <= w_shift;
      r_wdata  <= w_wdata;
      r_ptr    <= w_ptr;
      r_oe     <= w_oe;
      r_ack_ph <= w_ack_ph;
      r_rw     <= w_rw;
      r_busy   <= w_busy;
      r_wr     <= w_wr;
    end
  end

  assign i2c_sda_oe = r_oe;
  assign reg_addr   = r_ptr;
  assign reg_wdata  = r_wdata;
  assign reg_wr     = r_wr;
  assign reg_rd     = w_rd & ~rst;
  assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed bench for i2c_slave_regbank: a bit-banged master drives the bus,
// a small bank model answers reads, and a monitor process scores queued
// expectations against DUT writes and sampled bus/port values.
module tb_i2c_slave_regbank;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe, reg_wr, reg_rd, busy;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic [7:0] bank [16] = '{0: 8'h33, 14: 8'h11, 15: 8'h22, default: 8'h00};

  always #5 clk = ~clk;

  assign sda_line  = m_sda & ~sda_oe;
  assign reg_rdata = bank[reg_addr];
  always @(posedge clk) if (reg_wr) bank[reg_addr] <= reg_wdata;

  i2c_slave_regbank #(.SLAVE_ADDR(7'h2A), .DEPTH(16), .FILTER_LEN(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_scl_in (m_scl),
    .i2c_sda_in (sda_line),
    .i2c_sda_oe (sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rdata  (reg_rdata),
    .reg_rd     (reg_rd),
    .busy       (busy)
  );

  typedef struct { logic [3:0] addr; logic [7:0] data; } wr_t;
  typedef struct { string name; int act; int exp; } chk_t;
  wr_t  exp_wr[$];
  chk_t chk_q[$];
  wr_t  e_wr;
  chk_t e_chk;
  int   nvec = 0, nerr = 0;
  int   rd_cnt = 0, oe_cnt = 0, start_cnt = 0;
  bit   done = 1'b0;

  // Monitor: scores every write strobe and every queued observation.
  always @(negedge clk) begin
    if (reg_rd)  rd_cnt++;
    if (sda_oe)  oe_cnt++;
    if (dut.w_start) start_cnt++;
    if (reg_wr) begin
      nvec++;
      if (exp_wr.size() == 0) begin
        nerr++;
        $display("FAIL wr_unexpected: got addr=%0h data=%02h, required no write", reg_addr, reg_wdata);
      end else begin
        e_wr = exp_wr.pop_front();
        if (reg_addr !== e_wr.addr || reg_wdata !== e_wr.data) begin
          nerr++;
          $display("FAIL wr_strobe: got addr=%0h data=%02h, required addr=%0h data=%02h",
                   reg_addr, reg_wdata, e_wr.addr, e_wr.data);
        end
      end
    end
    while (chk_q.size() > 0) begin
      e_chk = chk_q.pop_front();
      nvec++;
      if (e_chk.act !== e_chk.exp) begin
        nerr++;
        $display("FAIL %s: got %0h, required %0h", e_chk.name, e_chk.act, e_chk.exp);
      end
    end
    if (done) begin
      nvec++;
      if (exp_wr.size() != 0) begin
        nerr++;
        $display("FAIL wr_missing: got %0d writes outstanding, required 0", exp_wr.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input int a, input int e);
    chk_q.push_back('{n, a, e});
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    clks(5); m_sda = b; clks(5); m_scl = 1'b1; clks(5); s = sda_line; clks(5); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    clks(5); m_sda = 1'b1; clks(5); m_scl = 1'b1; clks(5); m_sda = 1'b0; clks(5); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(5); m_sda = 1'b0; clks(5); m_scl = 1'b1; clks(5); m_sda = 1'b1; clks(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin bit_xfer(1'b1, s); b[i] = s; end
    bit_xfer(nack, s);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         snap;

    // Reset state
    clks(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_reg_rd", reg_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_state", int'(dut.r_state), int'(IDLE));
    rst = 1'b0;
    clks(10);

    // Write burst: ptr 3, A5 -> [3], 5A -> [4]
    exp_wr.push_back('{4'h3, 8'hA5});
    exp_wr.push_back('{4'h4, 8'h5A});
    i2c_start();
    send_byte(8'h54, a); chk("wb_addr_ack", a, 0);
    chk("wb_busy_hi", busy, 1);
    send_byte(8'h03, a); chk("wb_ptr_ack", a, 0);
    send_byte(8'hA5, a); chk("wb_d0_ack", a, 0);
    send_byte(8'h5A, a); chk("wb_d1_ack", a, 0);
    i2c_stop();
    chk("wb_busy_lo", busy, 0);
    chk("wb_ptr_after", reg_addr, 5);

    // Read after repeated START from 14, wrapping to 0
    snap = rd_cnt;
    i2c_start();
    send_byte(8'h54, a); chk("rd_addr_ack", a, 0);
    send_byte(8'h0E, a); chk("rd_ptr_ack", a, 0);
    i2c_start();
    send_byte(8'h55, a); chk("rd_raddr_ack", a, 0);
    recv_byte(1'b0, d); chk("rd_byte0", d, 8'h11);
    recv_byte(1'b0, d); chk("rd_byte1", d, 8'h22);
    recv_byte(1'b1, d); chk("rd_byte2_wrap", d, 8'h33);
    clks(3);
    chk("rd_state_idle", int'(dut.r_state), int'(IDLE));
    chk("rd_busy_lo", busy, 0);
    chk("rd_ptr_wrap", reg_addr, 0);
    chk("rd_pulses", rd_cnt - snap, 3);
    i2c_stop();

    // Wrong address: ignored, then a matched START is ACKed
    snap = oe_cnt;
    i2c_start();
    send_byte(8'h60, a); chk("wa_addr_nack", a, 1);
    send_byte(8'h12, a); chk("wa_d0_nack", a, 1);
    send_byte(8'h34, a); chk("wa_d1_nack", a, 1);
    chk("wa_oe_never", oe_cnt - snap, 0);
    i2c_start();
    send_byte(8'h54, a); chk("wa_next_ack", a, 0);
    send_byte(8'h07, a); chk("wa_ptr_ack", a, 0);
    i2c_stop();
    chk("wa_ptr", reg_addr, 7);

    // STOP after 4 bits of a data byte: partial byte dropped
    i2c_start();
    send_byte(8'h54, a); chk("ps_addr_ack", a, 0);
    send_byte(8'h05, a); chk("ps_ptr_ack", a, 0);
    bit_xfer(1'b1, a); bit_xfer(1'b0, a); bit_xfer(1'b1, a); bit_xfer(1'b1, a);
    i2c_stop();
    chk("ps_state_idle", int'(dut.r_state), int'(IDLE));
    chk("ps_sda_oe", sda_oe, 0);
    chk("ps_busy", busy, 0);
    chk("ps_ptr_kept", reg_addr, 5);

    // Reset mid read while the DUT is pulling SDA low (bank[1] = 00)
    i2c_start();
    send_byte(8'h54, a);
    send_byte(8'h01, a);
    i2c_start();
    send_byte(8'h55, a); chk("rr_raddr_ack", a, 0);
    clks(8);
    chk("rr_oe_driving", sda_oe, 1);
    chk("rr_state_rd", int'(dut.r_state), int'(RD_DATA));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rr_oe_released", sda_oe, 0);
    chk("rr_addr_reset", reg_addr, 0);
    chk("rr_busy_reset", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    i2c_stop();

    // 1-clk SDA low glitch while SCL high
    snap = start_cnt;
    @(negedge clk); m_sda = 1'b0;
    @(negedge clk); m_sda = 1'b1;
    clks(15);
`ifdef I2C_GLITCH_FILTER_EN
    chk("gl_start_count", start_cnt - snap, 0);
`else
    chk("gl_start_count", start_cnt - snap, 1);
`endif
    chk("gl_busy", busy, 0);
    chk("gl_state_idle", int'(dut.r_state), int'(IDLE));

    clks(5);
    done = 1'b1;
    clks(5);
  end

endmodule

// File: doc/i2c_slave_regbank.md
Name: i2c_slave_regbank

Overview:
- Fully synchronous, parametrised successor to the existing I2C target.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Decodes a configurable 7-bit address and exposes a byte-wide register bank port with an auto-incrementing pointer.
- Supports multi-byte write and read bursts; sits between the board I2C pads (open-drain) and a local control/status register block.

Parameters:
- SLAVE_ADDR, 7'h2A, 7-bit device address matched against the first byte after START.
- DEPTH, 16, number of bank locations; pointer wraps modulo DEPTH; must be a power of two, 2..256.
- PTR_W, $clog2(DEPTH), pointer/address width (derived, not overridden).
- FILTER_LEN, 3, glitch-filter length in clk cycles; only used with I2C_GLITCH_FILTER_EN.

Ports:
- clk  in  1  system clock; must be ≥ 8× SCL frequency.
- rst  in  1  synchronous active-high reset.
- i2c_scl_in  in  1  raw SCL pad input, asynchronous.
- i2c_sda_in  in  1  raw SDA pad input, asynchronous.
- i2c_sda_oe  out  1  1 = pull SDA low; 0 = release. Pad is open-drain, never driven high.
- reg_addr  out  PTR_W  current bank pointer; used for both read and write.
- reg_wdata  out  8  write data, valid while reg_wr is high.
- reg_wr  out  1  one-cycle write strobe.
- reg_rdata  in  8  bank read data, combinational from reg_addr; sampled by the slave.
- reg_rd  out  1  one-cycle pulse on the cycle reg_rdata is latched into the shift register.
- busy  out  1  high from an address-matched START until STOP or NACK-return-to-IDLE.

Behaviour:
- Input conditioning:
  - 2-flop synchronisers on SCL and SDA, then a registered previous-value copy for edge detection.
  - Detection latency from pad to event is 3 clk.
- Bus events, evaluated every clk:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - rise/fall = SCL edges.
- Data timing:
  - SDA is sampled on SCL rise.
  - i2c_sda_oe changes only on the clk after an SCL fall, never while SCL is high.
- Reset values: i2c_sda_oe=0, reg_wr=0, reg_rd=0, busy=0, reg_addr=0, state=IDLE, bit counter=7.
- State machine (START from any state → ADDR with bit counter reloaded and sda_oe released, i.e. repeated START is supported):
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. On the 8th rise: if addr[7:1]==SLAVE_ADDR go to ADDR_ACK, else IGNORE.
  - IGNORE: sda_oe=0; only START or STOP leaves this state.
  - ADDR_ACK: drive sda_oe=1 for the 9th clock. On the following fall:
    - W bit → PTR.
    - R bit → load reg_rdata (reg_rd pulse) and go to RD_DATA.
  - PTR: shift 8 bits; reg_addr <= byte[PTR_W-1:0] (upper bits ignored) → PTR_ACK (ACK) → WR_DATA.
  - WR_DATA: shift 8 bits → WR_ACK. During WR_ACK:
    - Drive ACK.
    - Pulse reg_wr for exactly one clk with reg_wdata.
    - reg_addr increments (mod DEPTH) on the clk after the strobe.
    - Then return to WR_DATA.
  - RD_DATA: present bit [7] on sda_oe (oe = ~bit) after each SCL fall; 8 bits → RD_ACK. sda_oe is released for the 9th bit.
  - RD_ACK: sample the master's bit on rise.
    - ACK (0): reg_addr increments, then reg_rd loads the next byte → RD_DATA.
    - NACK (1): → IDLE, busy drops.
- STOP in any state → IDLE, sda_oe released within 1 clk. A STOP mid-byte discards the partial byte with no reg_wr.
- A write burst crossing DEPTH-1 wraps to 0; a read burst does the same.
- The pointer persists across transactions (until rst), so a read without a pointer write continues from the last pointer.
- rst asserted mid-transfer: all outputs return to reset values on the next clk; the bus is released.

Optional Feature:
- I2C_GLITCH_FILTER_EN defined:
  - SCL and SDA each pass through a FILTER_LEN-sample agreement filter after the synchroniser.
  - The output changes only when all FILTER_LEN samples agree.
  - Adds FILTER_LEN clk of latency; pulses shorter than FILTER_LEN clk are rejected.
- Not defined: the filter is absent; the synchroniser feeds edge detection directly.
- Port list is identical in both builds.

Decomposition:
- Package i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, IGNORE, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK) and the RW-bit constants.
- Sub-module i2c_bus_cond: synchroniser, optional glitch filter and start/stop/rise/fall detector. It is reusable by the future master.

Test Plan:
- Write burst: START, 0x54 (addr 0x2A, W), ptr 0x03, data 0xA5, 0x5A, STOP → ACK on all 4 bytes; reg_wr pulses at addr 3 = 0xA5 and addr 4 = 0x5A; busy falls after STOP.
- Read after repeated START: START, 0x54, ptr 0x0E, Sr, 0x55, read 3 bytes ACK/ACK/NACK with bank[14]=0x11, [15]=0x22, [0]=0x33 → SDA returns 0x11, 0x22, 0x33 (wrap verified); IDLE after NACK.
- Wrong address 0x30 W followed by data bytes → no ACK, sda_oe never asserted, no reg_wr; next START to 0x54 is ACKed.
- STOP after 4 bits of a data byte → no reg_wr, state IDLE, sda_oe=0.
- rst pulsed during RD_DATA while sda_oe=1 → sda_oe=0 and reg_addr=0 on next clk.
- With I2C_GLITCH_FILTER_EN, a 1-clk SDA low pulse while SCL high → no START detected; without the macro the same pulse is detected as a START.
